lsu_stb_queue: RTL
==================

# lsu_stb_queue

Parametrised store buffer for the LSU: a DEPTH-entry circular queue of byte-masked stores with integrated enqueue control, in-order drain to the data cache over a req/ack handshake, load-to-store forwarding, and a flush (fence) mode. It sits between the LSU/MMU store path and the D-cache write port. It adds byte masks, forwarding, flush and configurable geometry to the fixed-size buffer controller it supersedes.

## Interface
- DEPTH, 8: number of entries; power of two, ≥2
- ADDR_W, 32: address width
- DATA_W, 32: data width; multiple of 8; BE_W = DATA_W/8, OFS = log2(BE_W)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- lsummu2stb_req / lsummu2stb_w_en / dmem_sel_i  in  1 each  store valid = all three high
- lsummu2stb_addr  in  ADDR_W  store address
- lsummu2stb_wdata  in  DATA_W  store data
- lsummu2stb_sel_byte  in  BE_W  byte mask
- stb2lsummu_ack  out  1  one-cycle pulse, store accepted in previous cycle
- stb2lsummu_stall  out  1  store valid but not accepted this cycle
- lsummu2stb_ld_addr  in  ADDR_W  load lookup address
- stb2lsummu_fwd_hit  out  1  youngest match covers all bytes
- stb2lsummu_fwd_data  out  DATA_W  forwarded data (0 when no hit)
- stb2lsummu_ld_stall  out  1  match exists but not a full hit
- lsummu2stb_flush  in  1  fence pulse
- stb2lsummu_flush_done  out  1  one-cycle pulse, flush complete
- stb2dcache_req  out  1  drain request
- stb2dcache_addr / _wdata / _sel_byte  out  ADDR_W / DATA_W / BE_W  head entry
- dcache2stb_ack  in  1  drain write accepted
- stb_full / stb_empty  out  1  count==DEPTH / count==0
- stb_count  out  log2(DEPTH)+1  occupancy

## Operation
- Storage: addr, data, mask arrays; wr_ptr, rd_ptr of log2(DEPTH) bits, wrap naturally; registered count.
- Enqueue: push at clock edge when store valid && !stb_full && !flush_active; write at wr_ptr, wr_ptr++.
- stb2lsummu_stall = store valid && (stb_full || flush_active); combinational.
- Full is registered: a pop in the same cycle does not admit a push at full.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Drain FSM: D_IDLE, D_REQ.
  - D_IDLE: if !stb_empty → D_REQ.
  - D_REQ: stb2dcache_req=1, addr/wdata/sel_byte = entry[rd_ptr], held stable; on dcache2stb_ack pop (rd_ptr++, count--) → D_IDLE.
  - Entry being drained stays valid and forwardable until its ack.
- Forwarding (combinational): match = valid entry with addr[ADDR_W-1:OFS] == ld_addr[ADDR_W-1:OFS]; youngest match (nearest behind wr_ptr) wins. fwd_hit = match && youngest mask all-ones; ld_stall = match && !fwd_hit.
- Flush: lsummu2stb_flush sets flush_active; stores stalled while set; when flush_active && count==0 → clear flush_active, pulse flush_done. Flush while flush_active is ignored.

## Timing
- Reset (rst high at edge): pointers, count=0, FSM D_IDLE, flush_active=0; outputs ack=0, stall=0, flush_done=0, stb2dcache_req=0, drain buses 0, stb_full=0, stb_empty=1, stb_count=0, fwd outputs 0. Reset mid-handshake abandons the drain; entries lost.
- Push at edge N → ack high cycle N+1 only; entry visible to forwarding from N+1.
- Push into empty buffer at edge N → FSM D_REQ at N+1 → req high cycle N+2.
- Ack at edge M → pop; req low in M+1; re-asserted M+2 if not empty. Max drain: one entry per 2 cycles.
- Flush on empty buffer at edge N → flush_done high cycle N+2 (flag set at N, cleared at N+1).
- stb_full, stb_empty, stb_count update the cycle after the edge causing the change.

## Test plan
- Reset, DEPTH=4: push 4 stores (A=0x100..0x10C, data 0x11..0x44), dcache ack held 0 → 4 acks, stb_full=1, 5th store sees stall=1 and no ack.
- Hold ack 1 from reset after 3 pushes → dcache writes in order 0x100,0x104,0x108, req gap of one cycle between each, stb_empty=1 afterward.
- Push 0x200 mask 0xF data 0xAAAA, then 0x200 mask 0xF data 0xBBBB; load 0x202 → fwd_hit=1, fwd_data=0xBBBB; push 0x300 mask 0x3 then load 0x300 → ld_stall=1, fwd_hit=0.
- At full with ack and store valid same cycle → pop occurs, push refused (stall=1), count=3; next cycle store accepted.
- 3 entries then flush pulse; stores during flush → stall=1; flush_done pulses one cycle after last drain ack, count=0.
- Assert rst during D_REQ with 2 entries → next cycle req=0, stb_empty=1, count=0.

Source files
------------

// File: rtl/lsu_stb_queue.sv
// LSU store buffer: circular queue of byte-masked stores between the LSU/MMU
// store path and the D-cache write port. Drains in order over req/ack,
// forwards the youngest fully-covering store to loads, and supports a fence.
module lsu_stb_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lsummu2stb_req,
  input  logic                      lsummu2stb_w_en,
  input  logic                      dmem_sel_i,
  input  logic [ADDR_W-1:0]         lsummu2stb_addr,
  input  logic [DATA_W-1:0]         lsummu2stb_wdata,
  input  logic [DATA_W/8-1:0]       lsummu2stb_sel_byte,
  output logic                      stb2lsummu_ack,
  output logic                      stb2lsummu_stall,
  input  logic [ADDR_W-1:0]         lsummu2stb_ld_addr,
  output logic                      stb2lsummu_fwd_hit,
  output logic [DATA_W-1:0]         stb2lsummu_fwd_data,
  output logic                      stb2lsummu_ld_stall,
  input  logic                      lsummu2stb_flush,
  output logic                      stb2lsummu_flush_done,
  output logic                      stb2dcache_req,
  output logic [ADDR_W-1:0]         stb2dcache_addr,
  output logic [DATA_W-1:0]         stb2dcache_wdata,
  output logic [DATA_W/8-1:0]       stb2dcache_sel_byte,
  input  logic                      dcache2stb_ack,
  output logic                      stb_full,
  output logic                      stb_empty,
  output logic [$clog2(DEPTH):0]    stb_count
);
  localparam int BE_W = DATA_W / 8;
  localparam int OFS  = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int PW   = $clog2(DEPTH);

  typedef enum logic {D_IDLE, D_REQ} drain_e;

  drain_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BE_W-1:0]   mask_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q;
  logic              ack_q, flush_active_q, flush_done_q;
  logic              store_vld, push, pop, full, empty;
  logic              fwd_found;
  logic [PW-1:0]     fwd_idx, scan_idx;

  // Full comes from the registered count, so a same-cycle pop never frees a slot
  // for a push; the refused store simply retries next cycle.
  assign full      = (count_q == (PW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign store_vld = lsummu2stb_req && lsummu2stb_w_en && dmem_sel_i;
  assign push      = store_vld && !full && !flush_active_q;
  assign pop       = (state_q == D_REQ) && dcache2stb_ack;

  assign stb2lsummu_ack        = ack_q;
  assign stb2lsummu_stall      = store_vld && (full || flush_active_q);
  assign stb2lsummu_flush_done = flush_done_q;
  assign stb_full              = full;
  assign stb_empty             = empty;
  assign stb_count             = count_q;

  // Head entry is presented only while a drain request is outstanding.
  assign stb2dcache_req      = (state_q == D_REQ);
  assign stb2dcache_addr     = stb2dcache_req ? addr_q[rd_ptr_q] : '0;
  assign stb2dcache_wdata    = stb2dcache_req ? data_q[rd_ptr_q] : '0;
  assign stb2dcache_sel_byte = stb2dcache_req ? mask_q[rd_ptr_q] : '0;

  // Control state: pointers, occupancy, accept pulse, fence tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ack_q          <= 1'b0;
      flush_active_q <= 1'b0;
      flush_done_q   <= 1'b0;
    end else begin
      ack_q <= push;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
      // A fence pulse during an active fence is ignored; completion is the
      // first cycle the buffer is seen empty.
      flush_done_q   <= flush_active_q && empty;
      flush_active_q <= flush_active_q ? !empty : lsummu2stb_flush;
    end
  end

  // Entry storage; contents of free slots are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= lsummu2stb_addr;
      data_q[wr_ptr_q] <= lsummu2stb_wdata;
      mask_q[wr_ptr_q] <= lsummu2stb_sel_byte;
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= D_IDLE;
    else     state_q <= state_d;
  end

  // Drain FSM next state: request the head, drop for one cycle after each ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      D_IDLE:  if (!empty) state_d = D_REQ;
      D_REQ:   if (dcache2stb_ack) state_d = D_IDLE;
      default: state_d = D_IDLE;
    endcase
  end

  // Forwarding scan oldest-to-youngest so the last match seen is the youngest.
  // The head being drained is still valid until its ack pops it.
  always_comb begin
    fwd_found = 1'b0;
    fwd_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + PW'(i);
      if (((PW+1)'(i) < count_q) &&
          (addr_q[scan_idx][ADDR_W-1:OFS] == lsummu2stb_ld_addr[ADDR_W-1:OFS])) begin
        fwd_found = 1'b1;
        fwd_idx   = scan_idx;
      end
    end
  end

  assign stb2lsummu_fwd_hit   = fwd_found && (&mask_q[fwd_idx]);
  assign stb2lsummu_fwd_data  = stb2lsummu_fwd_hit ? data_q[fwd_idx] : '0;
  assign stb2lsummu_ld_stall  = fwd_found && !stb2lsummu_fwd_hit;

  // Byte-offset bits of the load address do not take part in matching.
  generate
    if (OFS > 0) begin : g_ofs
      logic ld_ofs_unused;
      assign ld_ofs_unused = ^lsummu2stb_ld_addr[OFS-1:0];
    end
  endgenerate
endmodule
